// File: rtl/instr_loader.sv
// instr_loader: receives a length-prefixed, XOR-checksummed byte stream and writes it into instruction RAM
module instr_loader #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR} state_t;
    state_t state_q, state_d;
    logic [15:0] len_q, len_d, addr_q, addr_d, cnt_q, cnt_d;
    logic [15:0] wr_addr_q, wr_addr_d, wr_data_q, wr_data_d;
    logic [7:0] hi_q, hi_d, acc_q, acc_d;
    logic wr_en_q, wr_en_d, xfer;
    logic [16:0] n_full;
    assign rx_ready = state_q == LEN_HI || state_q == LEN_LO || state_q == DATA_HI ||
                      state_q == DATA_LO || state_q == CHECK;
    assign xfer = rx_valid && rx_ready;
    assign n_full = {1'b0, len_q[15:8], rx_data};
    assign cpu_hold = !(state_q == IDLE || state_q == DONE);
    assign done = state_q == DONE;
    assign error = state_q == ERR;
    assign wr_en = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign word_count = cnt_q;
    always_comb begin
        state_d = state_q;
        len_d = len_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        hi_d = hi_q;
        acc_d = acc_q;
        wr_en_d = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            IDLE, DONE, ERR: if (start) begin
                state_d = LEN_HI;
                cnt_d = '0;
                acc_d = '0;
                addr_d = '0;
            end
            LEN_HI: if (xfer) begin
                len_d[15:8] = rx_data;
                state_d = LEN_LO;
            end
            LEN_LO: if (xfer) begin
                len_d[7:0] = rx_data;
                state_d = n_full > 17'(DEPTH) ? ERR : n_full == 17'd0 ? CHECK : DATA_HI;
            end
            DATA_HI: if (xfer) begin
                hi_d = rx_data;
                acc_d = acc_q ^ rx_data;
                state_d = DATA_LO;
            end
            DATA_LO: if (xfer) begin
                wr_en_d = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = {hi_q, rx_data};
                acc_d = acc_q ^ rx_data;
                addr_d = addr_q + 16'd1;
                cnt_d = cnt_q + 16'd1;
                state_d = cnt_q + 16'd1 == len_q ? CHECK : DATA_HI;
            end
            CHECK: if (xfer) state_d = rx_data == acc_q ? DONE : ERR;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q <= '0;
            addr_q <= '0;
            cnt_q <= '0;
            hi_q <= '0;
            acc_q <= '0;
            wr_en_q <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            len_q <= len_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            hi_q <= hi_d;
            acc_q <= acc_d;
            wr_en_q <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: table-driven and directed checks of the boot byte loader
module tb_instr_loader;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic rx_ready, wr_en, cpu_hold, done, error;
    logic [15:0] wr_addr, wr_data, word_count;
    int checks = 0, failures = 0, wr_total = 0;
    typedef struct {
        logic st;
        logic vld;
        logic [7:0] d;
        logic [52:0] exp;
    } vec_t;
    vec_t tbl[$];
    logic [15:0] words[4];
    logic [7:0] csum;
    instr_loader #(.DEPTH(256)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cpu_hold(cpu_hold), .done(done), .error(error), .word_count(word_count)
    );
    always #5 clk = ~clk;
    always @(negedge clk) if (wr_en) wr_total++;
    function automatic logic [52:0] pk(input logic rdy, we, input logic [15:0] wa, wd,
                                       input logic h, dn, er, input logic [15:0] wc);
        return {rdy, we, wa, wd, h, dn, er, wc};
    endfunction
    function automatic vec_t mk(input logic st, vld, input logic [7:0] d, input logic [52:0] exp);
        vec_t v;
        v.st = st;
        v.vld = vld;
        v.d = d;
        v.exp = exp;
        return v;
    endfunction
    function automatic logic [52:0] outs();
        return {rx_ready, wr_en, wr_addr, wr_data, cpu_hold, done, error, word_count};
    endfunction
    task automatic step(input logic r, s, v, input logic [7:0] d);
        @(negedge clk);
        rst = r;
        start = s;
        rx_valid = v;
        rx_data = d;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string name, input logic [52:0] act, exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask
    task automatic send(input logic [7:0] b);
        repeat ($urandom_range(0, 2)) step(0, 0, 0, 8'hEE);
        step(0, 0, 1, b);
    endtask
    initial begin
        // A: good 2-word image, one stall cycle in LEN_LO, byte offered in DONE is refused
        tbl.push_back(mk(1, 0, 8'h00, pk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h00, pk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 0, 8'h02, pk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h02, pk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h30, pk(1, 0, 16'h0000, 16'h0000, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h11, pk(1, 1, 16'h0000, 16'h3011, 1, 0, 0, 1)));
        tbl.push_back(mk(0, 1, 8'h31, pk(1, 0, 16'h0000, 16'h3011, 1, 0, 0, 1)));
        tbl.push_back(mk(0, 1, 8'h21, pk(1, 1, 16'h0001, 16'h3121, 1, 0, 0, 2)));
        tbl.push_back(mk(0, 1, 8'h31, pk(0, 0, 16'h0001, 16'h3121, 0, 1, 0, 2)));
        tbl.push_back(mk(0, 1, 8'h55, pk(0, 0, 16'h0001, 16'h3121, 0, 1, 0, 2)));
        // B: restart from DONE with rx_valid high, same image with bad checksum
        tbl.push_back(mk(1, 1, 8'hAA, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h00, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h02, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h30, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h11, pk(1, 1, 16'h0000, 16'h3011, 1, 0, 0, 1)));
        tbl.push_back(mk(0, 1, 8'h31, pk(1, 0, 16'h0000, 16'h3011, 1, 0, 0, 1)));
        tbl.push_back(mk(0, 1, 8'h21, pk(1, 1, 16'h0001, 16'h3121, 1, 0, 0, 2)));
        tbl.push_back(mk(0, 1, 8'h32, pk(0, 0, 16'h0001, 16'h3121, 1, 0, 1, 2)));
        tbl.push_back(mk(0, 1, 8'h32, pk(0, 0, 16'h0001, 16'h3121, 1, 0, 1, 2)));
        // C: N=257 exceeds DEPTH
        tbl.push_back(mk(1, 0, 8'h00, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h01, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h01, pk(0, 0, 16'h0001, 16'h3121, 1, 0, 1, 0)));
        // D: empty image
        tbl.push_back(mk(1, 0, 8'h00, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h00, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h00, pk(1, 0, 16'h0001, 16'h3121, 1, 0, 0, 0)));
        tbl.push_back(mk(0, 1, 8'h00, pk(0, 0, 16'h0001, 16'h3121, 0, 1, 0, 0)));
        step(1, 0, 0, 8'h00);
        step(1, 1, 1, 8'h99);
        chk("reset", outs(), 53'd0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(0, tbl[i].st, tbl[i].vld, tbl[i].d);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        // E: 4 words with random gaps and an ignored start pulse mid-data
        words = '{16'h1234, 16'hABCD, 16'h0F0F, 16'h8001};
        csum = 8'h00;
        step(0, 1, 0, 8'h00);
        send(8'h00);
        send(8'h04);
        for (int k = 0; k < 4; k++) begin
            if (k == 2) begin
                step(0, 1, 0, 8'h00);
                chk("start_ignored", outs(), pk(1, 0, 16'h0001, words[1], 1, 0, 0, 2));
            end
            send(words[k][15:8]);
            send(words[k][7:0]);
            chk($sformatf("gap_wr%0d", k), {wr_en, wr_addr, wr_data, word_count},
                {1'b1, 16'(k), words[k], 16'(k + 1)});
            csum = csum ^ words[k][15:8] ^ words[k][7:0];
        end
        send(csum);
        chk("gap_done", outs(), pk(0, 0, 16'h0003, words[3], 0, 1, 0, 4));
        // F: reset mid-session, then a fresh load from address 0
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h03);
        step(0, 0, 1, 8'h11);
        step(0, 0, 1, 8'h22);
        chk("pre_rst_wr", outs(), pk(1, 1, 16'h0000, 16'h1122, 1, 0, 0, 1));
        step(1, 1, 1, 8'h33);
        chk("mid_rst", outs(), 53'd0);
        step(0, 0, 1, 8'h44);
        chk("post_rst", outs(), 53'd0);
        step(0, 1, 0, 8'h00);
        step(0, 0, 1, 8'h00);
        step(0, 0, 1, 8'h01);
        step(0, 0, 1, 8'hAB);
        step(0, 0, 1, 8'hCD);
        chk("fresh_wr", outs(), pk(1, 1, 16'h0000, 16'hABCD, 1, 0, 0, 1));
        step(0, 0, 1, 8'h66);
        chk("fresh_done", outs(), pk(0, 0, 16'h0000, 16'hABCD, 0, 1, 0, 1));
        step(0, 0, 0, 8'h00);
        chk("write_total", 53'(wr_total), 53'd10);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
